// File: rtl/i2s_pkg.sv
// Shared types and constants for the i2s sample scheduler and its FIFO.
package i2s_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int UNDERRUN_W = 16;

    typedef enum logic [1:0] {
        MUTED    = 2'd0,
        RUN      = 2'd1,
        UNDERRUN = 2'd2
    } sched_state_t;

    // Counter sticks at all-ones instead of wrapping back to zero.
    function automatic logic [UNDERRUN_W-1:0] sat_inc(input logic [UNDERRUN_W-1:0] value);
        return (&value) ? value : value + UNDERRUN_W'(1);
    endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Synchronous FIFO of stereo pairs. The head entry is readable combinationally,
// so the data is valid in the same cycle that pop_i is asserted.
module i2s_sample_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Flush wins over both push and pop; full/empty guard the pointers.
    assign do_push = push_i & ~full_o  & ~flush_i;
    assign do_pop  = pop_i  & ~empty_o & ~flush_i;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is not reset; level_q alone decides which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/i2s_sample_sched.sv
// Sample scheduler: buffers stereo pairs and hands exactly one pair to the i2s
// transmitter per LRCLK frame, with prefill, mute-on-underrun and an underrun counter.
module i2s_sample_sched
    import i2s_pkg::*;
#(
    parameter  int DATA_W     = DATA_W_DEF,
    parameter  int FIFO_DEPTH = 8,
    parameter  int PREFILL    = 4,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_W-1:0]     s_data_l_i,
    input  logic [DATA_W-1:0]     s_data_r_i,
    input  logic                  tx_lrclk_i,
    output logic [DATA_W-1:0]     audio_l_o,
    output logic [DATA_W-1:0]     audio_r_o,
    output logic                  running_o,
    output logic [LVL_W-1:0]      fifo_level_o,
    output logic [UNDERRUN_W-1:0] underrun_cnt_o
);

    sched_state_t          state_q, state_d;
    logic                  lr_q;
    logic                  strobe;
    logic [DATA_W-1:0]     audio_l_q, audio_l_d;
    logic [DATA_W-1:0]     audio_r_q, audio_r_d;
    logic                  running_q;
    logic [UNDERRUN_W-1:0] underrun_cnt_q, underrun_cnt_d;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_flush;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [2*DATA_W-1:0]   fifo_rdata;
    logic [LVL_W-1:0]      fifo_level;
    logic                  prefilled;

    // Rising LRCLK marks the start of the right half-frame; lr_q resets high so
    // a high LRCLK right after reset is not mistaken for an edge.
    assign strobe     = tx_lrclk_i & ~lr_q;
    assign s_ready_o  = ~fifo_full & ~reset_i;
    assign fifo_push  = s_valid_i & s_ready_o & enable_i;
    assign fifo_flush = ~enable_i;
    assign prefilled  = (fifo_level >= LVL_W'(PREFILL));

    i2s_sample_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .wdata_i ({s_data_l_i, s_data_r_i}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        state_d        = state_q;
        audio_l_d      = audio_l_q;
        audio_r_d      = audio_r_q;
        underrun_cnt_d = underrun_cnt_q;
        fifo_pop       = 1'b0;
        if (!enable_i) begin
            state_d = MUTED;
            if (strobe) begin
                audio_l_d = '0;
                audio_r_d = '0;
            end
        end else if (strobe) begin
            audio_l_d = '0;
            audio_r_d = '0;
            case (state_q)
                MUTED, UNDERRUN: begin
                    if (prefilled) begin
                        state_d                = RUN;
                        fifo_pop               = 1'b1;
                        {audio_l_d, audio_r_d} = fifo_rdata;
                    end
                end
                RUN: begin
                    if (fifo_empty) begin
                        state_d        = UNDERRUN;
                        underrun_cnt_d = sat_inc(underrun_cnt_q);
                    end else begin
                        fifo_pop               = 1'b1;
                        {audio_l_d, audio_r_d} = fifo_rdata;
                    end
                end
                default: state_d = MUTED;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lr_q           <= 1'b1;
            state_q        <= MUTED;
            audio_l_q      <= '0;
            audio_r_q      <= '0;
            running_q      <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            lr_q           <= tx_lrclk_i;
            state_q        <= state_d;
            audio_l_q      <= audio_l_d;
            audio_r_q      <= audio_r_d;
            running_q      <= (state_d == RUN);
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign audio_l_o      = audio_l_q;
    assign audio_r_o      = audio_r_q;
    assign running_o      = running_q;
    assign fifo_level_o   = fifo_level;
    assign underrun_cnt_o = underrun_cnt_q;

endmodule
